pwm_fade_sched: RTL and testbench

//  Controller for the 4-channel PWM datapath: owns the shared period counter, per-channel

---
 rtl/pwm_fade_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_pwm_fade_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_sched.sv
// pwm_fade_sched: controller for a multi-channel PWM datapath.
//
// Owns the shared period counter, the per-channel duty registers and a fade
// sequencer. The sequencer ramps each channel's current duty toward a target
// programmed through a valid/ready config port. The duty that drives the
// outputs (duty_act) is reloaded only at period wrap, so an output never
// glitches mid-period.
//
// Optional build macro:
//   PWM_POL_EN  adds input pol[NCH-1:0]; each output is inverted where pol is set.
//               The reset value of pwm_out stays 0 either way.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   pol         in   NCH    per-channel output polarity (PWM_POL_EN only)
//   cfg_valid   in   1      config write request
//   cfg_ready   out  1      write accepted on an edge where cfg_valid & cfg_ready
//   cfg_ch      in   CHW    channel to program
//   cfg_target  in   CW     target duty in counts of PERIOD (values > PERIOD clamp)
//   cfg_div     in   DIVW   periods per 1-count fade step; 0 jumps straight to target
//   pwm_out     out  NCH    registered PWM outputs
//   busy        out  NCH    channel still fading (current duty != target)
//   done_pulse  out  1      one-cycle strobe: a channel reached its target
//   done_ch     out  CHW    channel for done_pulse; meaningful only while it is high

module pwm_fade_sched #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CW     = 7,
    parameter int unsigned PERIOD = 100,
    parameter int unsigned DIVW   = 16,
    localparam int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef PWM_POL_EN
    input  logic [NCH-1:0]  pol,
`endif
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [CW-1:0]   cfg_target,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  pwm_out,
    output logic [NCH-1:0]  busy,
    output logic            done_pulse,
    output logic [CHW-1:0]  done_ch
);

    localparam logic [CW-1:0]  DUTY_MAX = CW'(PERIOD);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CHW-1:0] IDX_LAST = CHW'(NCH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StUpdate
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [CHW-1:0]    idx_q, idx_d;
    logic [CW-1:0]     cntr_q;
    logic              wrap;

    // duty_cur is the sequencer's working (shadow) duty; duty_act drives outputs.
    logic [CW-1:0]     duty_cur_q [NCH];
    logic [CW-1:0]     duty_cur_d [NCH];
    logic [CW-1:0]     duty_act_q [NCH];
    logic [CW-1:0]     tgt_q      [NCH];
    logic [CW-1:0]     tgt_d      [NCH];
    logic [DIVW-1:0]   div_q      [NCH];
    logic [DIVW-1:0]   div_d      [NCH];
    logic [DIVW-1:0]   pre_q      [NCH];
    logic [DIVW-1:0]   pre_d      [NCH];

    logic [NCH-1:0]    busy_q, busy_d;
    logic              done_pulse_q, done_pulse_d;
    logic [CHW-1:0]    done_ch_q, done_ch_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [NCH-1:0]    pwm_raw, pwm_d, pwm_q;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    assign wrap = (cntr_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr_q <= '0;
        end else if (wrap) begin
            cntr_q <= '0;
        end else begin
            cntr_q <= cntr_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Active duty reload, only at wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act_q[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < NCH; i++) begin
                duty_act_q[i] <= duty_cur_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM compare and output register
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pwm_raw[i] = (cntr_q < duty_act_q[i]);
        end
`ifdef PWM_POL_EN
        pwm_d = pwm_raw ^ pol;
`else
        pwm_d = pwm_raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    // ------------------------------------------------------------------
    // Fade sequencer
    // ------------------------------------------------------------------
    logic              cfg_accept;
    logic [CW-1:0]     tgt_clamped;
    logic [CW-1:0]     sel_cur;
    logic [CW-1:0]     sel_tgt;
    logic [DIVW-1:0]   sel_div;
    logic [DIVW-1:0]   sel_pre;
    logic [DIVW:0]     pre_inc;
    logic              step_due;
    logic [CW-1:0]     step_duty;

    assign cfg_accept  = cfg_valid & cfg_ready_q;
    assign tgt_clamped = (cfg_target > DUTY_MAX) ? DUTY_MAX : cfg_target;

    assign sel_cur = duty_cur_q[idx_q];
    assign sel_tgt = tgt_q[idx_q];
    assign sel_div = div_q[idx_q];
    assign sel_pre = pre_q[idx_q];

    // One extra bit so pre+1 cannot wrap when div is all ones.
    assign pre_inc  = {1'b0, sel_pre} + (DIVW + 1)'(1);
    assign step_due = (sel_div == '0) || (pre_inc >= {1'b0, sel_div});

    always_comb begin
        if (sel_div == '0) begin
            step_duty = sel_tgt;
        end else if (sel_tgt > sel_cur) begin
            step_duty = sel_cur + CW'(1);
        end else if (sel_tgt < sel_cur) begin
            step_duty = sel_cur - CW'(1);
        end else begin
            step_duty = sel_cur;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        duty_cur_d   = duty_cur_q;
        tgt_d        = tgt_q;
        div_d        = div_q;
        pre_d        = pre_q;
        busy_d       = busy_q;
        done_pulse_d = 1'b0;
        done_ch_d    = done_ch_q;

        case (state_q)
            StIdle: begin
                if (cfg_accept) begin
                    tgt_d[cfg_ch]  = tgt_clamped;
                    div_d[cfg_ch]  = cfg_div;
                    pre_d[cfg_ch]  = '0;
                    // Retargeting onto the current duty simply stops the fade, silently.
                    busy_d[cfg_ch] = (tgt_clamped != duty_cur_q[cfg_ch]);
                end
                // A write accepted on the wrap edge is already in the registers
                // by the time UPDATE visits its channel.
                if (wrap) begin
                    state_d = StUpdate;
                    idx_d   = '0;
                end
            end

            StUpdate: begin
                if (busy_q[idx_q]) begin
                    if (step_due) begin
                        duty_cur_d[idx_q] = step_duty;
                        pre_d[idx_q]      = '0;
                        if (step_duty == sel_tgt) begin
                            busy_d[idx_q] = 1'b0;
                            done_pulse_d  = 1'b1;
                            done_ch_d     = idx_q;
                        end
                    end else begin
                        pre_d[idx_q] = sel_pre + DIVW'(1);
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + CHW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        cfg_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            busy_q       <= '0;
            done_pulse_q <= 1'b0;
            done_ch_q    <= '0;
            cfg_ready_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                duty_cur_q[i] <= '0;
                tgt_q[i]      <= '0;
                div_q[i]      <= '0;
                pre_q[i]      <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
            done_ch_q    <= done_ch_d;
            cfg_ready_q  <= cfg_ready_d;
            for (int i = 0; i < NCH; i++) begin
                duty_cur_q[i] <= duty_cur_d[i];
                tgt_q[i]      <= tgt_d[i];
                div_q[i]      <= div_d[i];
                pre_q[i]      <= pre_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_ready  = cfg_ready_q;
    assign pwm_out    = pwm_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
    assign done_ch    = done_ch_q;

endmodule

// File: tb/tb_pwm_fade_sched.sv
// Bench for pwm_fade_sched: table of config writes with expected busy/duty,
// a done_ch scoreboard queue, and hand-written multi-period sequences.

module tb_pwm_fade_sched;

    localparam int NCH    = 4;
    localparam int CW     = 7;
    localparam int PERIOD = 100;
    localparam int DIVW   = 16;
    localparam int CHW    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [CW-1:0]   cfg_target = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic [NCH-1:0]  pwm_out;
    logic [NCH-1:0]  busy;
    logic            done_pulse;
    logic [CHW-1:0]  done_ch;
`ifdef PWM_POL_EN
    logic [NCH-1:0]  pol = '0;
`endif

    pwm_fade_sched #(
        .NCH    (NCH),
        .CW     (CW),
        .PERIOD (PERIOD),
        .DIVW   (DIVW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef PWM_POL_EN
        .pol        (pol),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_target (cfg_target),
        .cfg_div    (cfg_div),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .done_pulse (done_pulse),
        .done_ch    (done_ch)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int mon_exp;

    typedef struct {
        int ch;
        int tgt;
        int div;
        int duty;   // expected high cycles per period once applied
        int busy;   // expected busy[ch] right after accept
        int done;   // a done_pulse is expected
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every done_pulse must match the oldest expected channel.
    always @(negedge clk) begin
        if (done_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done_ch", int'(done_ch), -1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_ch", int'(done_ch), mon_exp);
            end
        end
    end

    // All tasks below are entered and left at a negedge.
    task automatic do_write(input int ch, input int tgt, input int div);
        int n = 0;
        while (!cfg_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check("ready_timeout", int'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_target = CW'(tgt);
        cfg_div    = DIVW'(div);
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic count_high(input int ch, output int cnt);
        cnt = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[ch]) cnt++;
        end
    endtask

    // Counts wraps (cfg_ready falling) until done_pulse or the bound expires.
    task automatic fade_watch(input int ch, input int bound,
                              output int falls, output int busy_low, output int seen);
        int n = 0;
        logic prev = 1'b1;
        falls = 0;
        busy_low = 0;
        seen = 0;
        while (seen == 0 && n < bound) begin
            if (prev && !cfg_ready) falls++;
            prev = cfg_ready;
            if (done_pulse) begin
                seen = 1;
            end else begin
                if (!busy[ch]) busy_low++;
                @(negedge clk);
                n++;
            end
        end
    endtask

    int hi, falls, busy_low, seen, low, n;
    logic prev;

    initial begin
        // ch, tgt, div, duty, busy, done
        vecs[0] = '{0,  25, 0,  25, 1, 1};
        vecs[1] = '{3, 120, 0, 100, 1, 1};  // clamps to PERIOD
        vecs[2] = '{2,   0, 0,   0, 0, 0};  // already at target
        vecs[3] = '{1, 100, 0, 100, 1, 1};
        vecs[4] = '{0,   0, 0,   0, 1, 1};
        vecs[5] = '{1,   0, 0,   0, 1, 1};
        vecs[6] = '{3, 101, 0, 100, 0, 0};  // clamped value equals current
        vecs[7] = '{2,  99, 0,  99, 1, 1};

        // Reset state
        #1;
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_pulse", int'(done_pulse), 0);
        check("rst_done_ch", int'(done_ch), 0);
        check("rst_cfg_ready", int'(cfg_ready), 0);
        repeat (3) @(negedge clk);
        check("rst_cntr_held", int'(dut.cntr_q), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", int'(cfg_ready), 1);

        // Table-driven writes
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].done != 0) exp_q.push_back(vecs[v].ch);
            do_write(vecs[v].ch, vecs[v].tgt, vecs[v].div);
            check($sformatf("busy_v%0d", v), int'(busy[vecs[v].ch]), vecs[v].busy);
            wait_done($sformatf("done_timeout_v%0d", v), 300);
            repeat (250) @(negedge clk);
            count_high(vecs[v].ch, hi);
            check($sformatf("duty_v%0d", v), hi, vecs[v].duty);
        end

        // cfg_valid held across a wrap stalls for the NCH update cycles
        n = 0;
        while (!cfg_ready && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (cfg_ready && n < 300) begin @(negedge clk); n++; end
        exp_q.push_back(0);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_target = 7'd30;
        cfg_div    = 16'd0;
        low = 1;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 20) begin low++; @(negedge clk); n++; end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("stall_cycles", low, NCH);
        check("stall_busy", int'(busy[0]), 1);
        wait_done("stall_done_timeout", 300);
        repeat (250) @(negedge clk);
        count_high(0, hi);
        check("stall_duty", hi, 30);

        // Retarget ch2 mid-fade: 40 -> 80 at div 1, turned round at 60 toward 10
        exp_q.push_back(2);
        do_write(2, 40, 0);
        wait_done("rt_setup_timeout", 300);
        do_write(2, 80, 1);
        falls = 0;
        n = 0;
        prev = 1'b1;
        while (falls < 20 && n < 2500) begin
            if (prev && !cfg_ready) falls++;
            prev = cfg_ready;
            if (falls < 20) begin @(negedge clk); n++; end
        end
        check("rt_up_wraps", falls, 20);
        check("rt_busy_mid", int'(busy[2]), 1);
        exp_q.push_back(2);
        do_write(2, 10, 1);
        fade_watch(2, 6000, falls, busy_low, seen);
        check("rt_down_seen", seen, 1);
        check("rt_down_wraps", falls, 50);
        check("rt_down_busy_gap", busy_low, 0);
        wait_done("rt_done_timeout", 10);
        repeat (250) @(negedge clk);
        count_high(2, hi);
        check("rt_duty", hi, 10);

        // Slow fade ch1 0 -> 50 at div 2: one step per two periods
        exp_q.push_back(1);
        do_write(1, 50, 2);
        fade_watch(1, 11000, falls, busy_low, seen);
        check("slow_seen", seen, 1);
        check("slow_wraps", falls, 100);
        check("slow_busy_gap", busy_low, 0);
        wait_done("slow_done_timeout", 10);
        repeat (250) @(negedge clk);
        count_high(1, hi);
        check("slow_duty", hi, 50);

        // Asynchronous reset in the middle of a fade
        do_write(0, 50, 5);
        repeat (300) @(negedge clk);
        check("pre_rst_busy0", int'(busy[0]), 1);
        check("pre_rst_pwm3", int'(pwm_out[3]), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_pwm_out", int'(pwm_out), 0);
        check("async_busy", int'(busy), 0);
        check("async_cntr", int'(dut.cntr_q), 0);
        check("async_done_pulse", int'(done_pulse), 0);
        check("async_cfg_ready", int'(cfg_ready), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rerelease", int'(cfg_ready), 1);
        count_high(3, hi);
        check("post_rst_duty3", hi, 0);
        repeat (300) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
